pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronises the PLL lock indication and releases the
// per-domain resets one at a time, fastest domain first. Any lock loss after
// release has begun asserts every reset again and increments a saturating
// loss counter.
module pll_reset_sequencer #(
    parameter int unsigned NUM_RST       = 5,
    parameter int unsigned STABLE_CYCLES = 64,
    parameter int unsigned STEP_CYCLES   = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic               clk_in_n,
    input  logic               reset,
    input  logic               locked,
    input  logic               sw_rst_req,
    input  logic               clr_sticky,
    output logic [NUM_RST-1:0] rst_out,
    output logic               seq_done,
    output logic               lock_lost_sticky,
    output logic [7:0]         lock_loss_cnt,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int unsigned IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_RST - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_RST-1:0] r_rst_out;
    logic               r_seq_done;
    logic               r_sticky;
    logic [7:0]         r_loss_cnt;
    logic               r_sync1;
    logic               r_sync2;
    logic               w_locked_s;
    logic               w_loss;

    assign w_locked_s       = r_sync2;
    assign rst_out          = r_rst_out;
    assign seq_done         = r_seq_done;
    assign lock_lost_sticky = r_sticky;
    assign lock_loss_cnt    = r_loss_cnt;
    assign state            = r_state;

    // Lock loss only counts once the release sequence has started.
    always_comb begin
        w_loss = 1'b0;
        if (!w_locked_s && (r_state == RELEASE || r_state == RUN)) begin
            w_loss = 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous PLL lock input.
    always_ff @(posedge clk_in_n or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= locked;
            r_sync2 <= r_sync1;
        end
    end

    // Sequencing FSM: lock loss beats software request beats normal stepping.
    always_ff @(posedge clk_in_n or posedge reset) begin
        if (reset) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '1;
            r_seq_done <= 1'b0;
        end else if (r_state == WAIT_LOCK) begin
            r_rst_out  <= '1;
            r_seq_done <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            if (w_locked_s) begin
                r_state <= STABLE;
            end
        end else if (!w_locked_s) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '1;
            r_seq_done <= 1'b0;
        end else if (sw_rst_req) begin
            r_state    <= STABLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_rst_out  <= '1;
            r_seq_done <= 1'b0;
        end else begin
            case (r_state)
                STABLE: begin
                    if (r_cnt == STABLE_LAST) begin
                        r_state <= RELEASE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt == STEP_LAST) begin
                        r_cnt            <= '0;
                        r_rst_out[r_idx] <= 1'b0;
                        if (r_idx == IDX_LAST) begin
                            r_state    <= RUN;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Loss bookkeeping: sticky flag (set wins over clear) and saturating count.
    always_ff @(posedge clk_in_n or posedge reset) begin
        if (reset) begin
            r_sticky   <= 1'b0;
            r_loss_cnt <= '0;
        end else begin
            if (w_loss) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
            if (w_loss && r_loss_cnt != 8'hFF) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (NUM_RST=3, STABLE=4, STEP=2).
module tb_pll_reset_sequencer;

    logic       clk_in_n = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       clr_sticky = 1'b0;
    logic [2:0] rst_out;
    logic       seq_done;
    logic       lock_lost_sticky;
    logic [7:0] lock_loss_cnt;
    logic [1:0] state;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned exp_loss = 0;

    typedef struct {
        logic       locked;
        logic       sw;
        logic       clr;
        logic [2:0] rst;
        logic       done;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[14];

    pll_reset_sequencer #(
        .NUM_RST(3),
        .STABLE_CYCLES(4),
        .STEP_CYCLES(2),
        .CNT_W(16)
    ) dut (
        .clk_in_n(clk_in_n),
        .reset(reset),
        .locked(locked),
        .sw_rst_req(sw_rst_req),
        .clr_sticky(clr_sticky),
        .rst_out(rst_out),
        .seq_done(seq_done),
        .lock_lost_sticky(lock_lost_sticky),
        .lock_loss_cnt(lock_loss_cnt),
        .state(state)
    );

    always #5 clk_in_n = ~clk_in_n;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in_n);
        #1;
    endtask

    // Row i: inputs applied before edge i+1 (edge 1 = first edge after locked rises),
    // outputs expected after that edge. e0 is edge 3.
    task automatic run_table(input string tag);
        for (int i = 0; i < 14; i++) begin
            locked     = tbl[i].locked;
            sw_rst_req = tbl[i].sw;
            clr_sticky = tbl[i].clr;
            tick();
            chk($sformatf("%s_row%0d_rst", tag, i), 32'(rst_out), 32'(tbl[i].rst));
            chk($sformatf("%s_row%0d_done", tag, i), 32'(seq_done), 32'(tbl[i].done));
            chk($sformatf("%s_row%0d_state", tag, i), 32'(state), 32'(tbl[i].st));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst"}, 32'(rst_out), 32'h7);
        chk({tag, "_done"}, 32'(seq_done), 32'h0);
        chk({tag, "_sticky"}, 32'(lock_lost_sticky), 32'h0);
        chk({tag, "_losscnt"}, 32'(lock_loss_cnt), 32'h0);
        chk({tag, "_state"}, 32'(state), 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd2};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 2'd2};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd2};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 2'd2};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 2'd2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 2'd2};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd3};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 2'd3};

        // Reset values.
        #12;
        chk_reset_vals("por");
        @(negedge clk_in_n);
        reset = 1'b0;
        #1;

        // Lock drop during STABLE: back to WAIT_LOCK, not a loss event.
        locked = 1'b1;
        repeat (3) tick();
        chk("stab_enter_state", 32'(state), 32'd1);
        locked = 1'b0;
        repeat (3) tick();
        chk("stab_drop_state", 32'(state), 32'd0);
        chk("stab_drop_rst", 32'(rst_out), 32'h7);
        chk("stab_drop_losscnt", 32'(lock_loss_cnt), 32'd0);
        chk("stab_drop_sticky", 32'(lock_lost_sticky), 32'd0);

        // Full release timing after relock.
        run_table("seq1");

        // Lock loss in RUN: takes effect on the third edge after locked falls.
        locked = 1'b0;
        repeat (2) tick();
        chk("loss_e2_rst", 32'(rst_out), 32'h0);
        chk("loss_e2_state", 32'(state), 32'd3);
        tick();
        exp_loss = 1;
        chk("loss_rst", 32'(rst_out), 32'h7);
        chk("loss_done", 32'(seq_done), 32'd0);
        chk("loss_state", 32'(state), 32'd0);
        chk("loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss));
        chk("loss_sticky", 32'(lock_lost_sticky), 32'd1);
        run_table("seq_relock");

        // Software reset request held in RUN.
        sw_rst_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sw_hold%0d_state", i), 32'(state), 32'd1);
            chk($sformatf("sw_hold%0d_rst", i), 32'(rst_out), 32'h7);
            chk($sformatf("sw_hold%0d_done", i), 32'(seq_done), 32'd0);
        end
        sw_rst_req = 1'b0;
        repeat (5) tick();
        chk("sw_e5_rst", 32'(rst_out), 32'h7);
        tick();
        chk("sw_e6_rst", 32'(rst_out), 32'h6);
        repeat (4) tick();
        chk("sw_run_rst", 32'(rst_out), 32'h0);
        chk("sw_run_state", 32'(state), 32'd3);
        chk("sw_losscnt", 32'(lock_loss_cnt), 32'(exp_loss));

        // Repeated loss events saturate the counter.
        for (int k = 0; k < 260; k++) begin
            int unsigned guard;
            locked = 1'b0;
            repeat (3) tick();
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            chk($sformatf("sat%0d_cnt", k), 32'(lock_loss_cnt), 32'(exp_loss));
            locked = 1'b1;
            guard = 0;
            while (state != 2'd2 && guard < 20) begin
                tick();
                guard++;
            end
            chk($sformatf("sat%0d_reach_release", k), 32'(state), 32'd2);
        end
        chk("sat_final", 32'(lock_loss_cnt), 32'd255);

        // clr_sticky coinciding with a loss edge: set wins.
        locked = 1'b0;
        repeat (2) tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_vs_loss_sticky", 32'(lock_lost_sticky), 32'd1);
        chk("clr_vs_loss_state", 32'(state), 32'd0);
        chk("clr_vs_loss_cnt", 32'(lock_loss_cnt), 32'd255);
        tick();
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("clr_alone_sticky", 32'(lock_lost_sticky), 32'd0);

        // Asynchronous reset mid-RELEASE.
        locked = 1'b1;
        repeat (9) tick();
        chk("pre_areset_rst", 32'(rst_out), 32'h6);
        chk("pre_areset_state", 32'(state), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("areset");
        @(negedge clk_in_n);
        reset = 1'b0;
        run_table("seq_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
